branch_resolve_unit: RTL and testbench

//   Resolve side of the global branch predictor. Queues each prediction made at

---
 rtl/branch_resolve_unit_if.sv | 57 +++++
 rtl/branch_resolve_unit.sv | 145 ++++++++++++++
 tb/tb_branch_resolve_unit.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit_if
// Description : Bundles the fetch push port, execute resolve port, flush,
//               predictor training port, redirect outputs and statistics of
//               the branch resolve unit.
//               master : driven by the surrounding pipeline (or a bench)
//               slave  : the branch_resolve_unit itself
//   pred_valid/pred_pc/pred_taken/pred_target  fetch push, pred_ready back
//   res_valid/res_taken/res_target             execute resolve of the head
//   flush                                      external squash
//   upd_en/upd_pc/upd_taken                    predictor training port
//   mispredict/redirect_pc                     fetch redirect
//   occupancy/n_branches/n_mispred             status and statistics
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_resolve_unit_if #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic             pred_valid;
  logic [PC_W-1:0]  pred_pc;
  logic             pred_taken;
  logic [PC_W-1:0]  pred_target;
  logic             pred_ready;
  logic             res_valid;
  logic             res_taken;
  logic [PC_W-1:0]  res_target;
  logic             flush;
  logic             upd_en;
  logic [PC_W-1:0]  upd_pc;
  logic             upd_taken;
  logic             mispredict;
  logic [PC_W-1:0]  redirect_pc;
  logic [OCC_W-1:0] occupancy;
  logic [31:0]      n_branches;
  logic [31:0]      n_mispred;

  modport master (
    output pred_valid, pred_pc, pred_taken, pred_target,
    input  pred_ready,
    output res_valid, res_taken, res_target, flush,
    input  upd_en, upd_pc, upd_taken, mispredict, redirect_pc,
    input  occupancy, n_branches, n_mispred
  );

  modport slave (
    input  pred_valid, pred_pc, pred_taken, pred_target,
    output pred_ready,
    input  res_valid, res_taken, res_target, flush,
    output upd_en, upd_pc, upd_taken, mispredict, redirect_pc,
    output occupancy, n_branches, n_mispred
  );
endinterface
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit
// Description : Resolve side of the global branch predictor. Each prediction
//               made at fetch is queued in a circular FIFO and checked, in
//               program order, against the outcome from execute. Drives the
//               predictor training port, raises mispredict/redirect and keeps
//               saturating branch / mispredict counters.
//   clk    : clock
//   rst_n  : synchronous reset, active-low, overrides every other input
//   bus    : branch_resolve_unit_if.slave (push, resolve, flush, training,
//            redirect, occupancy and statistics)
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  branch_resolve_unit_if.slave bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int OCC_W = AW + 1;
  localparam logic [PC_W-1:0]  C_PC_STEP = PC_W'(4);
  localparam logic [31:0]      C_CNT_MAX = 32'hFFFF_FFFF;
  localparam logic [OCC_W-1:0] C_FULL    = OCC_W'(DEPTH);

  // Entry storage: {pc, taken, target}
  logic [PC_W-1:0]  r_pc_q  [DEPTH];
  logic             r_tk_q  [DEPTH];
  logic [PC_W-1:0]  r_tgt_q [DEPTH];

  logic [AW-1:0]    r_rd;
  logic [AW-1:0]    r_wr;
  logic [OCC_W-1:0] r_occ;

  logic             r_upd_en;
  logic [PC_W-1:0]  r_upd_pc;
  logic             r_upd_taken;
  logic             r_mispredict;
  logic [PC_W-1:0]  r_redirect_pc;
  logic [31:0]      r_n_branches;
  logic [31:0]      r_n_mispred;

  logic             w_full;
  logic             w_pop;
  logic             w_mis;
  logic             w_push;
  logic [PC_W-1:0]  w_head_pc;
  logic             w_head_tk;
  logic [PC_W-1:0]  w_head_tgt;

  assign w_head_pc  = r_pc_q[r_rd];
  assign w_head_tk  = r_tk_q[r_rd];
  assign w_head_tgt = r_tgt_q[r_rd];
  assign w_full     = (r_occ == C_FULL);

  // A flush discards any same-cycle resolve; an empty queue ignores res_valid.
  assign w_pop = bus.res_valid && (r_occ != '0) && !bus.flush;

  // Target only matters when the branch was actually taken.
  assign w_mis = w_pop &&
                 ((w_head_tk != bus.res_taken) ||
                  (bus.res_taken && (w_head_tgt != bus.res_target)));

  // A push is lost when the queue is full, being flushed, or being squashed
  // by a mispredict at the same edge.
  assign w_push = bus.pred_valid && !w_full && !bus.flush && !w_mis;

  // Entry payload needs no reset: occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_q[r_wr]  <= bus.pred_pc;
      r_tk_q[r_wr]  <= bus.pred_taken;
      r_tgt_q[r_wr] <= bus.pred_taken ? bus.pred_target : '0;
    end
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_occ <= '0;
    end else if (bus.flush || w_mis) begin
      // Everything younger than the head is squashed; restart from slot 0.
      r_rd  <= '0;
      r_wr  <= '0;
      r_occ <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Registered training / redirect outputs, one cycle after the resolve edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_upd_en      <= 1'b0;
      r_upd_pc      <= '0;
      r_upd_taken   <= 1'b0;
      r_mispredict  <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_upd_en     <= w_pop;
      r_mispredict <= w_mis;
      if (w_pop) begin
        r_upd_pc    <= w_head_pc;
        r_upd_taken <= bus.res_taken;
      end
      if (w_mis) begin
        r_redirect_pc <= bus.res_taken ? bus.res_target : (w_head_pc + C_PC_STEP);
      end
    end
  end

  // Saturating statistics
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_n_branches <= '0;
      r_n_mispred  <= '0;
    end else begin
      if (w_pop && (r_n_branches != C_CNT_MAX)) r_n_branches <= r_n_branches + 1'b1;
      if (w_mis && (r_n_mispred  != C_CNT_MAX)) r_n_mispred  <= r_n_mispred + 1'b1;
    end
  end

  assign bus.pred_ready  = !w_full;
  assign bus.upd_en      = r_upd_en;
  assign bus.upd_pc      = r_upd_pc;
  assign bus.upd_taken   = r_upd_taken;
  assign bus.mispredict  = r_mispredict;
  assign bus.redirect_pc = r_redirect_pc;
  assign bus.occupancy   = r_occ;
  assign bus.n_branches  = r_n_branches;
  assign bus.n_mispred   = r_n_mispred;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve_unit
// Description : Self-checking bench for branch_resolve_unit: a table of
//               single-cycle push/resolve vectors followed by hand-written
//               sequences for full queue, flush, pointer wrap, counter
//               saturation and mid-run reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;
  localparam int DEPTH = 4;
  localparam int PC_W  = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_resolve_unit_if #(.DEPTH(DEPTH), .PC_W(PC_W)) bus ();

  branch_resolve_unit #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic        push;
    logic [31:0] ppc;
    logic        ptk;
    logic [31:0] ptgt;
    logic        res;
    logic        rtk;
    logic [31:0] rtgt;
    logic        e_upd;
    logic [31:0] e_pc;
    logic        e_tk;
    logic        e_mis;
    logic [31:0] e_redir;
    logic [2:0]  e_occ;
  } vec_t;

  vec_t vecs[12];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.pred_valid  = 1'b0;
    bus.pred_pc     = '0;
    bus.pred_taken  = 1'b0;
    bus.pred_target = '0;
    bus.res_valid   = 1'b0;
    bus.res_taken   = 1'b0;
    bus.res_target  = '0;
    bus.flush       = 1'b0;
  endtask

  // Advance one edge and sample 1 time unit after it; inputs then go idle.
  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic push(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    bus.pred_valid  = 1'b1;
    bus.pred_pc     = pc;
    bus.pred_taken  = tk;
    bus.pred_target = tgt;
  endtask

  task automatic resolve(input logic tk, input logic [31:0] tgt);
    bus.res_valid  = 1'b1;
    bus.res_taken  = tk;
    bus.res_target = tgt;
  endtask

  logic [31:0] exp_q[$];

  initial begin
    //          push ppc       ptk ptgt      res rtk rtgt     e_upd e_pc     e_tk e_mis e_redir   e_occ
    vecs[0]  = '{1, 32'h100, 1, 32'h200, 0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   3'd1};
    vecs[1]  = '{0, 32'h0,   0, 32'h0,   1, 1, 32'h200, 1, 32'h100, 1, 0, 32'h0,   3'd0};
    vecs[2]  = '{1, 32'h104, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   3'd1};
    vecs[3]  = '{0, 32'h0,   0, 32'h0,   1, 1, 32'h300, 1, 32'h104, 1, 1, 32'h300, 3'd0};
    vecs[4]  = '{1, 32'h108, 1, 32'h400, 0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   3'd1};
    vecs[5]  = '{0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   1, 32'h108, 0, 1, 32'h10C, 3'd0};
    vecs[6]  = '{1, 32'h10,  1, 32'h50,  0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   3'd1};
    vecs[7]  = '{1, 32'h20,  0, 32'h0,   1, 1, 32'h50,  1, 32'h10,  1, 0, 32'h0,   3'd1};
    vecs[8]  = '{0, 32'h0,   0, 32'h0,   1, 1, 32'h60,  1, 32'h20,  1, 1, 32'h60,  3'd0};
    vecs[9]  = '{1, 32'h30,  1, 32'h70,  0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   3'd1};
    vecs[10] = '{0, 32'h0,   0, 32'h0,   1, 1, 32'h74,  1, 32'h30,  1, 1, 32'h74,  3'd0};
    vecs[11] = '{0, 32'h0,   0, 32'h0,   1, 1, 32'h80,  0, 32'h0,   0, 0, 32'h0,   3'd0};

    idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    chk("reset occupancy",  32'(bus.occupancy), 32'd0);
    chk("reset pred_ready", 32'(bus.pred_ready), 32'd1);
    chk("reset upd_en",     32'(bus.upd_en), 32'd0);
    chk("reset mispredict", 32'(bus.mispredict), 32'd0);
    chk("reset upd_pc",     bus.upd_pc, 32'd0);
    chk("reset redirect",   bus.redirect_pc, 32'd0);
    chk("reset n_branches", bus.n_branches, 32'd0);
    chk("reset n_mispred",  bus.n_mispred, 32'd0);

    // Table-driven single-cycle vectors
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].push) push(vecs[i].ppc, vecs[i].ptk, vecs[i].ptgt);
      if (vecs[i].res)  resolve(vecs[i].rtk, vecs[i].rtgt);
      step();
      chk($sformatf("vec%0d upd_en", i),     32'(bus.upd_en), 32'(vecs[i].e_upd));
      chk($sformatf("vec%0d mispredict", i), 32'(bus.mispredict), 32'(vecs[i].e_mis));
      chk($sformatf("vec%0d occupancy", i),  32'(bus.occupancy), 32'(vecs[i].e_occ));
      if (vecs[i].e_upd) begin
        chk($sformatf("vec%0d upd_pc", i),    bus.upd_pc, vecs[i].e_pc);
        chk($sformatf("vec%0d upd_taken", i), 32'(bus.upd_taken), 32'(vecs[i].e_tk));
      end
      if (vecs[i].e_mis) chk($sformatf("vec%0d redirect_pc", i), bus.redirect_pc, vecs[i].e_redir);
    end
    chk("table n_branches", bus.n_branches, 32'd6);
    chk("table n_mispred",  bus.n_mispred, 32'd4);

    // Fill to full, drop a fifth push, then mispredict with a concurrent push
    for (int k = 0; k < DEPTH; k++) begin
      push(32'h200 + 32'(4 * k), 1'b1, 32'h1000 + 32'(k));
      step();
    end
    chk("full occupancy", 32'(bus.occupancy), 32'd4);
    chk("full pred_ready", 32'(bus.pred_ready), 32'd0);
    push(32'h300, 1'b1, 32'h2000);
    step();
    chk("dropped push occupancy", 32'(bus.occupancy), 32'd4);
    resolve(1'b0, 32'h0);
    push(32'h310, 1'b0, 32'h0);
    step();
    chk("squash occupancy", 32'(bus.occupancy), 32'd0);
    chk("squash mispredict", 32'(bus.mispredict), 32'd1);
    chk("squash redirect", bus.redirect_pc, 32'h204);
    chk("squash upd_pc", bus.upd_pc, 32'h200);
    chk("squash pred_ready", 32'(bus.pred_ready), 32'd1);
    step();
    chk("pulse width mispredict", 32'(bus.mispredict), 32'd0);
    chk("pulse width upd_en", 32'(bus.upd_en), 32'd0);

    // Flush with a same-cycle resolve and push
    for (int k = 0; k < 3; k++) begin
      push(32'h400 + 32'(4 * k), 1'b0, 32'h0);
      step();
    end
    chk("pre-flush occupancy", 32'(bus.occupancy), 32'd3);
    bus.flush = 1'b1;
    resolve(1'b1, 32'h999);
    push(32'h500, 1'b0, 32'h0);
    step();
    chk("flush occupancy", 32'(bus.occupancy), 32'd0);
    chk("flush upd_en", 32'(bus.upd_en), 32'd0);
    chk("flush mispredict", 32'(bus.mispredict), 32'd0);
    chk("flush n_branches", bus.n_branches, 32'd7);
    chk("flush n_mispred", bus.n_mispred, 32'd5);
    resolve(1'b1, 32'h0);
    step();
    chk("empty resolve upd_en", 32'(bus.upd_en), 32'd0);
    chk("empty resolve mispredict", 32'(bus.mispredict), 32'd0);
    chk("empty resolve n_branches", bus.n_branches, 32'd7);

    // 2*DEPTH+1 push/resolve pairs across pointer wrap
    exp_q.delete();
    push(32'h600, 1'b0, 32'h0);
    exp_q.push_back(32'h600);
    step();
    for (int k = 1; k <= 2 * DEPTH + 1; k++) begin
      push(32'h600 + 32'(4 * k), 1'b0, 32'h0);
      exp_q.push_back(32'h600 + 32'(4 * k));
      resolve(1'b0, 32'h0);
      step();
      chk($sformatf("wrap%0d upd_pc", k), bus.upd_pc, exp_q.pop_front());
      chk($sformatf("wrap%0d mispredict", k), 32'(bus.mispredict), 32'd0);
      chk($sformatf("wrap%0d occupancy", k), 32'(bus.occupancy), 32'd1);
    end
    resolve(1'b0, 32'h0);
    step();
    chk("wrap last upd_pc", bus.upd_pc, exp_q.pop_front());
    chk("wrap last occupancy", 32'(bus.occupancy), 32'd0);
    chk("wrap n_branches", bus.n_branches, 32'd17);

    // Saturation of the mispredict counter
    force dut.r_n_mispred = 32'hFFFF_FFFF;
    step();
    release dut.r_n_mispred;
    push(32'h700, 1'b0, 32'h0);
    step();
    resolve(1'b1, 32'h800);
    step();
    chk("sat mispredict", 32'(bus.mispredict), 32'd1);
    chk("sat n_mispred", bus.n_mispred, 32'hFFFF_FFFF);
    chk("sat n_branches", bus.n_branches, 32'd18);

    // Reset mid-operation with a pending resolve
    push(32'h900, 1'b1, 32'hA00);
    step();
    rst_n = 1'b0;
    resolve(1'b0, 32'h0);
    step();
    rst_n = 1'b1;
    chk("midreset occupancy", 32'(bus.occupancy), 32'd0);
    chk("midreset upd_en", 32'(bus.upd_en), 32'd0);
    chk("midreset mispredict", 32'(bus.mispredict), 32'd0);
    chk("midreset n_branches", bus.n_branches, 32'd0);
    chk("midreset n_mispred", bus.n_mispred, 32'd0);
    chk("midreset pred_ready", 32'(bus.pred_ready), 32'd1);
    step();
    chk("post-reset upd_en", 32'(bus.upd_en), 32'd0);
    chk("post-reset mispredict", 32'(bus.mispredict), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
